vend_ctrl_param: RTL and testbench
==================================

# vend_ctrl_param

Parametrised vending-machine controller: accepts up to three debounced coin channels of configurable value, accumulates credit, vends when credit reaches the configured price, then pays change or refunds under a valid/ack handshake. It sits between the key debouncer and the two SEG7_LUT digit decoders, replacing the fixed two-coin controller with price, coin values, vend time and inactivity timeout set by parameters.

## Interface
- PRICE, 25: item price in 0.1-yuan units; 1 ≤ PRICE ≤ CREDIT_MAX.
- COIN0_VAL, 5: value of coin[0] in 0.1-yuan units.
- COIN1_VAL, 10: value of coin[1].
- COIN2_VAL, 50: value of coin[2].
- CREDIT_MAX, 99: highest credit held; fixed limit for two-digit display.
- VEND_CYC, 25_000_000: cycles vend is asserted (0.5 s at 50 MHz); ≥ 1.
- TIMEOUT_CYC, 500_000_000: idle cycles in COLLECT before auto-refund; ≥ 1.
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- coin  in  3  one-cycle coin pulses from the debouncer.
- cancel  in  1  one-cycle cancel pulse.
- change_ack  in  1  payout mechanism has taken change_val.
- vend  out  1  high for VEND_CYC cycles during dispensing.
- change_val  out  7  change/refund amount, valid while change_valid.
- change_valid  out  1  change/refund pending.
- coin_reject  out  1  one-cycle pulse: a coin pulse was not accepted.
- disp_tens  out  4  BCD tens of displayed value.
- disp_ones  out  4  BCD ones of displayed value.
- led  out  6  status: [0] IDLE, [1] COLLECT, [2] VEND, [3] CHANGE, [4] REFUND, [5] reject seen since last IDLE.

## Operation
- States: IDLE, COLLECT, VEND, CHANGE, REFUND. Credit register: 7 bits.
- IDLE: credit = 0. Accepted coin → credit = value; go to VEND if value ≥ PRICE, else COLLECT.
- COLLECT: accepted coin → credit += value; go to VEND if the new credit ≥ PRICE. cancel → REFUND. Timeout counter reaching TIMEOUT_CYC → REFUND. The timeout counter clears on every accepted coin and on entry to COLLECT.
- VEND: vend = 1 for exactly VEND_CYC cycles. On exit, change_val = credit − PRICE; go to CHANGE if nonzero, else go to IDLE and clear credit.
- CHANGE/REFUND: change_valid = 1, change_val held stable (REFUND: change_val = credit). In the cycle change_ack = 1 → IDLE, credit = 0, change_valid = 0. change_ack outside CHANGE/REFUND is ignored.
- Coin arbitration: at most one coin is accepted per cycle, with the lowest index winning. Other simultaneous pulses are rejected.
- Rejected coin: any coin in VEND/CHANGE/REFUND, a losing simultaneous coin, a coin arriving in the same cycle as cancel (cancel wins), or a coin that would make credit > CREDIT_MAX. Credit is unchanged and coin_reject pulses. led[5] sets and stays set until IDLE is entered.
- Display value: credit in IDLE/COLLECT/VEND; change_val in CHANGE/REFUND. It is converted to BCD tens/ones (value ≤ 99).

## Timing
- Reset (asynchronous assert): state IDLE, credit 0, both counters 0, vend 0, change_val 0, change_valid 0, coin_reject 0, disp_tens/disp_ones 0, led 6'b000001. Reset asserted mid-VEND or mid-CHANGE discards credit, and no change is paid.
- A coin pulse in cycle N updates credit and state at edge N+1. coin_reject is high during cycle N+1. The display digits update at edge N+2 (registered BCD).
- vend rises at the edge that enters VEND and stays high for VEND_CYC cycles. The exit state and change_val are valid at the following edge.
- change_valid rises at the same edge as entry to CHANGE/REFUND. It falls at the edge after the cycle in which change_ack is sampled high, and state is IDLE from that edge.
- The timeout fires at the edge after TIMEOUT_CYC consecutive COLLECT cycles with no accepted coin.
- cancel in IDLE, VEND or CHANGE is ignored.

## Test plan
- Defaults; coin[1], coin[1], coin[0] on separate cycles → credit 10, 20, 25; vend high for VEND_CYC cycles; change_valid stays 0; return to IDLE with display 00.
- coin[2] (50) in IDLE → VEND; then CHANGE with change_val 25, display 2/5; hold change_ack low for 10 cycles (values stable); pulse ack → IDLE.
- coin[0] then cancel → REFUND with change_val 5; same-cycle coin[1]+cancel also tested → coin_reject pulse, refund of 5 only.
- TIMEOUT_CYC=100, coin[0] only → REFUND exactly 100 cycles later with change_val 5; a coin at cycle 60 restarts the count.
- coin[0] and coin[1] in the same cycle → credit 5, coin_reject 1 for one cycle, led[5] set. A coin during VEND → rejected and credit unchanged.
- PRICE=90, CREDIT_MAX=99: credit 50 (coin[2]), then coin[2] → rejected (would be 100). Also assert rst_n low mid-VEND → all outputs at reset values immediately.

Source files
------------

// File: rtl/vend_ctrl_param.sv
// ---------------------------------------------------------------------------
// vend_ctrl_param
//   Parametrised vending-machine controller. Accepts one coin per cycle from
//   up to three debounced coin channels, accumulates credit, vends once credit
//   reaches PRICE, then pays change (or refunds on cancel / inactivity) under
//   a change_valid / change_ack handshake. Drives two BCD display digits.
//
// Ports
//   clk           system clock (50 MHz)
//   rst_n         asynchronous active-low reset
//   coin[2:0]     one-cycle coin pulses, coin[0] has highest priority
//   cancel        one-cycle cancel pulse (honoured only while collecting)
//   change_ack    payout mechanism has taken change_val
//   vend          high for VEND_CYC cycles while dispensing
//   change_val    change / refund amount, valid while change_valid
//   change_valid  change / refund pending
//   coin_reject   one-cycle pulse, a coin pulse was not accepted
//   disp_tens     BCD tens of displayed value
//   disp_ones     BCD ones of displayed value
//   led[5:0]      [0] IDLE [1] COLLECT [2] VEND [3] CHANGE [4] REFUND
//                 [5] reject seen since IDLE was last entered
// ---------------------------------------------------------------------------
module vend_ctrl_param #(
  parameter int PRICE       = 25,
  parameter int COIN0_VAL   = 5,
  parameter int COIN1_VAL   = 10,
  parameter int COIN2_VAL   = 50,
  parameter int CREDIT_MAX  = 99,
  parameter int VEND_CYC    = 25_000_000,
  parameter int TIMEOUT_CYC = 500_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] coin,
  input  logic       cancel,
  input  logic       change_ack,
  output logic       vend,
  output logic [6:0] change_val,
  output logic       change_valid,
  output logic       coin_reject,
  output logic [3:0] disp_tens,
  output logic [3:0] disp_ones,
  output logic [5:0] led
);

  // Counters run 0 .. N-1, so N values need clog2(N) bits (at least one).
  localparam int VEND_W = (VEND_CYC    > 1) ? $clog2(VEND_CYC)    : 1;
  localparam int TO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_VEND,
    S_CHANGE,
    S_REFUND
  } state_t;

  state_t            state, state_nxt;
  logic [6:0]        credit, credit_nxt;
  logic [6:0]        change_val_nxt;
  logic [VEND_W-1:0] vend_cnt, vend_cnt_nxt;
  logic [TO_W-1:0]   to_cnt, to_cnt_nxt;
  logic              reject_seen;

  // Coin arbitration: lowest index wins, value widened to 8 bits so an
  // overflowing sum is still visible before it is compared to CREDIT_MAX.
  logic [2:0] coin_win;
  logic [7:0] coin_val;
  logic [7:0] credit_base;
  logic [7:0] credit_sum;
  logic       coin_open;
  logic       coin_ok;
  logic       reject_nxt;
  logic [6:0] disp_val;

  // NOTE: every signal assigned in an always_comb gets a default first, so
  // no path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    coin_win = 3'b000;
    coin_val = 8'd0;
    if (coin[0]) begin
      coin_win = 3'b001;
      coin_val = 8'(COIN0_VAL);
    end else if (coin[1]) begin
      coin_win = 3'b010;
      coin_val = 8'(COIN1_VAL);
    end else if (coin[2]) begin
      coin_win = 3'b100;
      coin_val = 8'(COIN2_VAL);
    end
  end

  assign credit_base = (state == S_IDLE) ? 8'd0 : {1'b0, credit};
  assign credit_sum  = credit_base + coin_val;
  // Coins are only taken while idle or collecting; a cancel in COLLECT beats
  // a same-cycle coin (cancel has no effect in IDLE, so the coin proceeds).
  assign coin_open   = (state == S_IDLE) || ((state == S_COLLECT) && !cancel);
  assign coin_ok     = coin_open && (coin_win != 3'b000) &&
                       (credit_sum <= 8'(CREDIT_MAX));
  // Any pulse that is not the accepted winner is a reject.
  assign reject_nxt  = |(coin & ~(coin_ok ? coin_win : 3'b000));

  // Next-state and datapath logic.
  always_comb begin
    state_nxt      = state;
    credit_nxt     = credit;
    change_val_nxt = change_val;
    vend_cnt_nxt   = vend_cnt;
    to_cnt_nxt     = to_cnt;
    case (state)
      S_IDLE: begin
        credit_nxt   = '0;
        vend_cnt_nxt = '0;
        to_cnt_nxt   = '0;
        if (coin_ok) begin
          credit_nxt = credit_sum[6:0];
          state_nxt  = (credit_sum >= 8'(PRICE)) ? S_VEND : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (cancel) begin
          state_nxt      = S_REFUND;
          change_val_nxt = credit;
          to_cnt_nxt     = '0;
        end else if (coin_ok) begin
          credit_nxt = credit_sum[6:0];
          to_cnt_nxt = '0;
          if (credit_sum >= 8'(PRICE)) state_nxt = S_VEND;
        end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
          state_nxt      = S_REFUND;
          change_val_nxt = credit;
          to_cnt_nxt     = '0;
        end else begin
          to_cnt_nxt = to_cnt + TO_W'(1);
        end
      end
      S_VEND: begin
        if (vend_cnt == VEND_W'(VEND_CYC - 1)) begin
          vend_cnt_nxt   = '0;
          change_val_nxt = credit - 7'(PRICE);
          if (credit != 7'(PRICE)) begin
            state_nxt = S_CHANGE;
          end else begin
            state_nxt  = S_IDLE;
            credit_nxt = '0;
          end
        end else begin
          vend_cnt_nxt = vend_cnt + VEND_W'(1);
        end
      end
      S_CHANGE, S_REFUND: begin
        if (change_ack) begin
          state_nxt      = S_IDLE;
          credit_nxt     = '0;
          change_val_nxt = '0;
        end
      end
      default: begin
        state_nxt  = S_IDLE;
        credit_nxt = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      credit      <= '0;
      change_val  <= '0;
      vend_cnt    <= '0;
      to_cnt      <= '0;
      coin_reject <= 1'b0;
      reject_seen <= 1'b0;
    end else begin
      state       <= state_nxt;
      credit      <= credit_nxt;
      change_val  <= change_val_nxt;
      vend_cnt    <= vend_cnt_nxt;
      to_cnt      <= to_cnt_nxt;
      coin_reject <= reject_nxt;
      // Entering IDLE clears the sticky reject flag.
      if ((state_nxt == S_IDLE) && (state != S_IDLE)) reject_seen <= 1'b0;
      else if (reject_nxt)                            reject_seen <= 1'b1;
    end
  end

  // Output decode from the current state.
  always_comb begin
    vend         = (state == S_VEND);
    change_valid = (state == S_CHANGE) || (state == S_REFUND);
    led          = {reject_seen,
                    state == S_REFUND,
                    state == S_CHANGE,
                    state == S_VEND,
                    state == S_COLLECT,
                    state == S_IDLE};
    disp_val     = change_valid ? change_val : credit;
  end

  // Registered BCD conversion; the displayed value never exceeds 99.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_tens <= 4'd0;
      disp_ones <= 4'd0;
    end else begin
      disp_tens <= 4'(disp_val / 7'd10);
      disp_ones <= 4'(disp_val % 7'd10);
    end
  end

endmodule

// File: tb/tb_vend_ctrl_param.sv
// ---------------------------------------------------------------------------
// tb_vend_ctrl_param
//   Directed bench for vend_ctrl_param. Instance u_a uses the default price
//   and coin values with a short vend time and a 100-cycle timeout; u_b uses
//   PRICE=90 for the credit-limit case. Inputs change 1 ns after the rising
//   edge and outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_vend_ctrl_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] coin_a, coin_b;
  logic       cancel_a, cancel_b, ack_a, ack_b;

  logic       vend_a, change_valid_a, coin_reject_a;
  logic [6:0] change_val_a;
  logic [3:0] disp_tens_a, disp_ones_a;
  logic [5:0] led_a;

  logic       vend_b, change_valid_b, coin_reject_b;
  logic [6:0] change_val_b;
  logic [3:0] disp_tens_b, disp_ones_b;
  logic [5:0] led_b;

  vend_ctrl_param #(.VEND_CYC(8), .TIMEOUT_CYC(100)) u_a (
    .clk(clk), .rst_n(rst_n), .coin(coin_a), .cancel(cancel_a),
    .change_ack(ack_a), .vend(vend_a), .change_val(change_val_a),
    .change_valid(change_valid_a), .coin_reject(coin_reject_a),
    .disp_tens(disp_tens_a), .disp_ones(disp_ones_a), .led(led_a)
  );

  vend_ctrl_param #(.PRICE(90), .VEND_CYC(8), .TIMEOUT_CYC(1000)) u_b (
    .clk(clk), .rst_n(rst_n), .coin(coin_b), .cancel(cancel_b),
    .change_ack(ack_b), .vend(vend_b), .change_val(change_val_b),
    .change_valid(change_valid_b), .coin_reject(coin_reject_b),
    .disp_tens(disp_tens_b), .disp_ones(disp_ones_b), .led(led_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_a(input logic [2:0] c, input logic can);
    coin_a = c; cancel_a = can;
    tick(1);
    coin_a = 3'b000; cancel_a = 1'b0;
  endtask

  task automatic pulse_b(input logic [2:0] c);
    coin_b = c;
    tick(1);
    coin_b = 3'b000;
  endtask

  task automatic ack_pulse_a();
    ack_a = 1'b1;
    tick(1);
    ack_a = 1'b0;
  endtask

  // Counts cycles until vend drops (bounded); also notes any change_valid.
  task automatic wait_vend_a(output int cyc, output logic cv);
    cyc = 0; cv = 1'b0;
    while (vend_a && cyc < 100) begin
      cv |= change_valid_a;
      tick(1);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    coin_a = 3'b000; cancel_a = 1'b0; ack_a = 1'b0;
    coin_b = 3'b000; cancel_b = 1'b0; ack_b = 1'b0;
    tick(2);
    n_cmp++;
    if ({vend_a, change_valid_a, coin_reject_a, led_a} !== {3'b000, 6'b000001}) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want %b",
               {vend_a, change_valid_a, coin_reject_a, led_a}, {3'b000, 6'b000001});
    end
    n_cmp++;
    if ({change_val_a, disp_tens_a, disp_ones_a} !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 0", {change_val_a, disp_tens_a, disp_ones_a});
    end
    rst_n = 1'b1;
    tick(1);
    n_cmp++;
    if ({led_b, led_a} !== {6'b000001, 6'b000001}) begin
      n_bad++;
      $display("FAIL reset_idle: got %b want %b", {led_b, led_a}, 12'b000001_000001);
    end
  endtask

  task automatic test_exact_price();
    int   cyc;
    logic cv;
    pulse_a(3'b010, 1'b0);
    n_cmp++;
    if ({coin_reject_a, led_a} !== 7'b0_000010) begin
      n_bad++;
      $display("FAIL exact_collect: got %b want %b", {coin_reject_a, led_a}, 7'b0_000010);
    end
    tick(1);
    n_cmp++;
    if ({disp_tens_a, disp_ones_a} !== 8'h10) begin
      n_bad++;
      $display("FAIL exact_disp10: got %h want 10", {disp_tens_a, disp_ones_a});
    end
    pulse_a(3'b010, 1'b0);
    tick(1);
    n_cmp++;
    if ({disp_tens_a, disp_ones_a} !== 8'h20) begin
      n_bad++;
      $display("FAIL exact_disp20: got %h want 20", {disp_tens_a, disp_ones_a});
    end
    pulse_a(3'b001, 1'b0);
    n_cmp++;
    if ({vend_a, led_a} !== 7'b1_000100) begin
      n_bad++;
      $display("FAIL exact_vend_entry: got %b want %b", {vend_a, led_a}, 7'b1_000100);
    end
    wait_vend_a(cyc, cv);
    n_cmp++;
    if (cyc !== 8) begin
      n_bad++;
      $display("FAIL exact_vend_len: got %0d want 8", cyc);
    end
    n_cmp++;
    if ({cv, change_valid_a, led_a} !== 8'b0_0_000001) begin
      n_bad++;
      $display("FAIL exact_no_change: got %b want %b", {cv, change_valid_a, led_a}, 8'b0_0_000001);
    end
    n_cmp++;
    if ({disp_tens_a, disp_ones_a} !== 8'h25) begin
      n_bad++;
      $display("FAIL exact_disp25: got %h want 25", {disp_tens_a, disp_ones_a});
    end
    tick(1);
    n_cmp++;
    if ({disp_tens_a, disp_ones_a} !== 8'h00) begin
      n_bad++;
      $display("FAIL exact_disp00: got %h want 00", {disp_tens_a, disp_ones_a});
    end
  endtask

  task automatic test_change();
    int   cyc;
    int   stable;
    logic cv;
    pulse_a(3'b100, 1'b0);
    n_cmp++;
    if ({vend_a, led_a} !== 7'b1_000100) begin
      n_bad++;
      $display("FAIL change_vend_entry: got %b want %b", {vend_a, led_a}, 7'b1_000100);
    end
    wait_vend_a(cyc, cv);
    n_cmp++;
    if ({change_valid_a, change_val_a, led_a} !== {1'b1, 7'd25, 6'b001000}) begin
      n_bad++;
      $display("FAIL change_entry: got %b want %b",
               {change_valid_a, change_val_a, led_a}, {1'b1, 7'd25, 6'b001000});
    end
    tick(1);
    n_cmp++;
    if ({disp_tens_a, disp_ones_a} !== 8'h25) begin
      n_bad++;
      $display("FAIL change_disp: got %h want 25", {disp_tens_a, disp_ones_a});
    end
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (change_valid_a === 1'b1 && change_val_a === 7'd25 && led_a === 6'b001000)
        stable++;
    end
    n_cmp++;
    if (stable !== 10) begin
      n_bad++;
      $display("FAIL change_hold: got %0d stable cycles want 10", stable);
    end
    ack_pulse_a();
    n_cmp++;
    if ({change_valid_a, led_a} !== 7'b0_000001) begin
      n_bad++;
      $display("FAIL change_ack: got %b want %b", {change_valid_a, led_a}, 7'b0_000001);
    end
  endtask

  task automatic test_cancel();
    pulse_a(3'b001, 1'b0);
    tick(1);
    pulse_a(3'b000, 1'b1);
    n_cmp++;
    if ({change_valid_a, change_val_a, led_a} !== {1'b1, 7'd5, 6'b010000}) begin
      n_bad++;
      $display("FAIL cancel_refund: got %b want %b",
               {change_valid_a, change_val_a, led_a}, {1'b1, 7'd5, 6'b010000});
    end
    tick(1);
    n_cmp++;
    if ({disp_tens_a, disp_ones_a} !== 8'h05) begin
      n_bad++;
      $display("FAIL cancel_disp: got %h want 05", {disp_tens_a, disp_ones_a});
    end
    ack_pulse_a();
    pulse_a(3'b001, 1'b0);
    pulse_a(3'b010, 1'b1);
    n_cmp++;
    if ({coin_reject_a, change_valid_a, change_val_a, led_a} !== {2'b11, 7'd5, 6'b110000}) begin
      n_bad++;
      $display("FAIL cancel_coin_same: got %b want %b",
               {coin_reject_a, change_valid_a, change_val_a, led_a}, {2'b11, 7'd5, 6'b110000});
    end
    tick(1);
    n_cmp++;
    if ({coin_reject_a, led_a} !== 7'b0_110000) begin
      n_bad++;
      $display("FAIL cancel_reject_pulse: got %b want %b", {coin_reject_a, led_a}, 7'b0_110000);
    end
    ack_pulse_a();
    n_cmp++;
    if (led_a !== 6'b000001) begin
      n_bad++;
      $display("FAIL cancel_led5_clear: got %b want 000001", led_a);
    end
  endtask

  task automatic test_timeout();
    int cyc;
    pulse_a(3'b001, 1'b0);
    cyc = 0;
    while (led_a[1] && cyc < 200) begin
      tick(1);
      cyc++;
    end
    n_cmp++;
    if (cyc !== 100) begin
      n_bad++;
      $display("FAIL timeout_len: got %0d want 100", cyc);
    end
    n_cmp++;
    if ({change_val_a, led_a} !== {7'd5, 6'b010000}) begin
      n_bad++;
      $display("FAIL timeout_refund: got %b want %b", {change_val_a, led_a}, {7'd5, 6'b010000});
    end
    ack_pulse_a();
    pulse_a(3'b001, 1'b0);
    tick(59);
    pulse_a(3'b001, 1'b0);
    cyc = 0;
    while (led_a[1] && cyc < 200) begin
      tick(1);
      cyc++;
    end
    n_cmp++;
    if (cyc !== 100) begin
      n_bad++;
      $display("FAIL timeout_restart: got %0d want 100", cyc);
    end
    n_cmp++;
    if ({change_val_a, led_a} !== {7'd10, 6'b010000}) begin
      n_bad++;
      $display("FAIL timeout_restart_val: got %b want %b", {change_val_a, led_a}, {7'd10, 6'b010000});
    end
    ack_pulse_a();
  endtask

  task automatic test_simultaneous();
    int   cyc;
    logic cv;
    pulse_a(3'b011, 1'b0);
    n_cmp++;
    if ({coin_reject_a, led_a} !== 7'b1_100010) begin
      n_bad++;
      $display("FAIL simul_reject: got %b want %b", {coin_reject_a, led_a}, 7'b1_100010);
    end
    tick(1);
    n_cmp++;
    if ({coin_reject_a, disp_tens_a, disp_ones_a} !== {1'b0, 8'h05}) begin
      n_bad++;
      $display("FAIL simul_credit5: got %h want 005", {coin_reject_a, disp_tens_a, disp_ones_a});
    end
    pulse_a(3'b010, 1'b0);
    pulse_a(3'b010, 1'b0);
    tick(1);
    pulse_a(3'b001, 1'b0);
    n_cmp++;
    if ({vend_a, coin_reject_a, led_a} !== 8'b1_1_100100) begin
      n_bad++;
      $display("FAIL vend_coin_reject: got %b want %b", {vend_a, coin_reject_a, led_a}, 8'b1_1_100100);
    end
    tick(1);
    n_cmp++;
    if ({disp_tens_a, disp_ones_a} !== 8'h25) begin
      n_bad++;
      $display("FAIL vend_credit_kept: got %h want 25", {disp_tens_a, disp_ones_a});
    end
    wait_vend_a(cyc, cv);
    n_cmp++;
    if ({cv, change_valid_a, led_a} !== 8'b0_0_000001) begin
      n_bad++;
      $display("FAIL vend_exit_idle: got %b want %b", {cv, change_valid_a, led_a}, 8'b0_0_000001);
    end
  endtask

  task automatic test_reset_mid_vend();
    pulse_a(3'b100, 1'b0);
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({vend_a, change_valid_a, coin_reject_a, led_a} !== {3'b000, 6'b000001}) begin
      n_bad++;
      $display("FAIL rst_mid_ctrl: got %b want %b",
               {vend_a, change_valid_a, coin_reject_a, led_a}, {3'b000, 6'b000001});
    end
    n_cmp++;
    if ({change_val_a, disp_tens_a, disp_ones_a} !== 15'd0) begin
      n_bad++;
      $display("FAIL rst_mid_data: got %h want 0", {change_val_a, disp_tens_a, disp_ones_a});
    end
    tick(2);
    rst_n = 1'b1;
    tick(12);
    n_cmp++;
    if ({change_valid_a, led_a, disp_tens_a, disp_ones_a} !== {1'b0, 6'b000001, 8'h00}) begin
      n_bad++;
      $display("FAIL rst_mid_no_change: got %b want %b",
               {change_valid_a, led_a, disp_tens_a, disp_ones_a}, {1'b0, 6'b000001, 8'h00});
    end
  endtask

  task automatic test_credit_limit();
    int cyc;
    pulse_b(3'b100);
    tick(1);
    n_cmp++;
    if ({disp_tens_b, disp_ones_b} !== 8'h50) begin
      n_bad++;
      $display("FAIL limit_disp50: got %h want 50", {disp_tens_b, disp_ones_b});
    end
    pulse_b(3'b100);
    n_cmp++;
    if ({coin_reject_b, led_b} !== 7'b1_100010) begin
      n_bad++;
      $display("FAIL limit_reject: got %b want %b", {coin_reject_b, led_b}, 7'b1_100010);
    end
    tick(1);
    n_cmp++;
    if ({disp_tens_b, disp_ones_b} !== 8'h50) begin
      n_bad++;
      $display("FAIL limit_credit_kept: got %h want 50", {disp_tens_b, disp_ones_b});
    end
    for (int i = 0; i < 4; i++) pulse_b(3'b010);
    n_cmp++;
    if ({vend_b, led_b} !== 7'b1_100100) begin
      n_bad++;
      $display("FAIL limit_vend90: got %b want %b", {vend_b, led_b}, 7'b1_100100);
    end
    cyc = 0;
    while (vend_b && cyc < 100) begin
      tick(1);
      cyc++;
    end
    n_cmp++;
    if ({cyc[7:0], change_valid_b, led_b} !== {8'd8, 1'b0, 6'b000001}) begin
      n_bad++;
      $display("FAIL limit_vend_exit: got %b want %b",
               {cyc[7:0], change_valid_b, led_b}, {8'd8, 1'b0, 6'b000001});
    end
  endtask

  initial begin
    test_reset();
    test_exact_price();
    test_change();
    test_cancel();
    test_timeout();
    test_simultaneous();
    test_reset_mid_vend();
    test_credit_limit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
